// File: rtl/button_event_decoder.sv
// Per-channel button event decoder: registered press/release/long/repeat pulses and held level, 1-cycle latency, no backpressure.
// Auto-repeat in HELD is built only when BUTTON_EVENT_REPEAT_EN is defined; otherwise repeat_pulse stays 0 and the HELD counter is idle.
module button_event_decoder #(
  parameter int WIDTH          = 1,
  parameter int LONG_CNT_MAX   = 25000,
  parameter int REPEAT_CNT_MAX = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_pulse,
  output logic [WIDTH-1:0] repeat_pulse,
  output logic [WIDTH-1:0] held
);

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif
  localparam int CNT_MAX = (REPEAT_ON && (REPEAT_CNT_MAX > LONG_CNT_MAX)) ? REPEAT_CNT_MAX
                                                                          : LONG_CNT_MAX;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT_MAX - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CNT_MAX - 1);
`endif

  typedef enum logic [1:0] {WAIT_LOW, IDLE, PRESSED, HELD} state_t;

  state_t          r_state  [WIDTH];
  logic [CW-1:0]   r_cnt    [WIDTH];
  state_t          w_nstate [WIDTH];
  logic [CW-1:0]   w_ncnt   [WIDTH];
  logic [WIDTH-1:0] w_press, w_rel, w_long, w_rep, w_held;

  // Release always takes priority over long/repeat on the same edge.
  always_comb begin
    w_press = '0;
    w_rel   = '0;
    w_long  = '0;
    w_rep   = '0;
    w_held  = '0;
    for (int c = 0; c < WIDTH; c++) begin
      w_nstate[c] = r_state[c];
      w_ncnt[c]   = r_cnt[c];
      case (r_state[c])
        WAIT_LOW: begin
          if (!in[c]) w_nstate[c] = IDLE;
        end
        IDLE: begin
          if (in[c]) begin
            w_nstate[c] = PRESSED;
            w_ncnt[c]   = CW'(1);
            w_press[c]  = 1'b1;
          end
        end
        PRESSED: begin
          if (!in[c]) begin
            w_nstate[c] = IDLE;
            w_ncnt[c]   = '0;
            w_rel[c]    = 1'b1;
          end else if (r_cnt[c] == LONG_LAST) begin
            w_nstate[c] = HELD;
            w_ncnt[c]   = '0;
            w_long[c]   = 1'b1;
          end else begin
            w_ncnt[c] = r_cnt[c] + CW'(1);
          end
        end
        HELD: begin
          if (!in[c]) begin
            w_nstate[c] = IDLE;
            w_ncnt[c]   = '0;
            w_rel[c]    = 1'b1;
          end
`ifdef BUTTON_EVENT_REPEAT_EN
          else if (r_cnt[c] == REP_LAST) begin
            w_ncnt[c] = '0;
            w_rep[c]  = 1'b1;
          end else begin
            w_ncnt[c] = r_cnt[c] + CW'(1);
          end
`endif
        end
        default: begin
          w_nstate[c] = WAIT_LOW;
          w_ncnt[c]   = '0;
        end
      endcase
      w_held[c] = (w_nstate[c] == HELD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < WIDTH; c++) begin
        r_state[c] <= WAIT_LOW;
        r_cnt[c]   <= '0;
      end
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      repeat_pulse  <= '0;
      held          <= '0;
    end else begin
      for (int c = 0; c < WIDTH; c++) begin
        r_state[c] <= w_nstate[c];
        r_cnt[c]   <= w_ncnt[c];
      end
      press_pulse   <= w_press;
      release_pulse <= w_rel;
      long_pulse    <= w_long;
      repeat_pulse  <= w_rep;
      held          <= w_held;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: a duration-based event model predicts each cycle's outputs.
module tb_button_event_decoder;
  localparam int W    = 2;
  localparam int LONG = 8;
  localparam int REP  = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] press;
    logic [W-1:0] rel;
    logic [W-1:0] lng;
    logic [W-1:0] rep;
    logic [W-1:0] held;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_s = '0;
  logic [W-1:0] press_pulse, release_pulse, long_pulse, repeat_pulse, held;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  ev_t exp_q[$];

  // Model state: armed once a low level is seen after reset; dur counts sampled-high edges of a press.
  bit armed    [W];
  bit pressing [W];
  int dur      [W];

  always #5 clk = ~clk;

  button_event_decoder #(
    .WIDTH(W), .LONG_CNT_MAX(LONG), .REPEAT_CNT_MAX(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in_s),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held)
  );

  function automatic void model_step(input logic [W-1:0] v, input logic rst, output ev_t e);
    e = '0;
    for (int c = 0; c < W; c++) begin
      if (!rst) begin
        armed[c] = 1'b0;
        pressing[c] = 1'b0;
        dur[c] = 0;
      end else if (!armed[c]) begin
        if (!v[c]) armed[c] = 1'b1;
      end else if (v[c]) begin
        if (!pressing[c]) begin
          pressing[c] = 1'b1;
          dur[c] = 1;
          e.press[c] = 1'b1;
        end else begin
          dur[c]++;
          if (dur[c] == LONG) e.lng[c] = 1'b1;
          else if (REP_ON && dur[c] > LONG && ((dur[c] - LONG) % REP) == 0) e.rep[c] = 1'b1;
        end
        e.held[c] = (dur[c] >= LONG);
      end else if (pressing[c]) begin
        pressing[c] = 1'b0;
        dur[c] = 0;
        e.rel[c] = 1'b1;
      end
    end
  endfunction

  task automatic cycle(input logic [W-1:0] v);
    ev_t e;
    @(negedge clk);
    in_s = v;
    model_step(v, rst_n, e);
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} != '0) begin
      n_errors++;
      $display("FAIL %s: outputs p=%b r=%b l=%b rp=%b h=%b, required all 0", name,
               press_pulse, release_pulse, long_pulse, repeat_pulse, held);
    end
  endtask

  task automatic pulse_reset(input int len);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (len) cycle(in_s);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: outputs are valid every cycle; compare each against the oldest prediction.
  initial begin
    ev_t e;
    ev_t got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = '{press_pulse, release_pulse, long_pulse, repeat_pulse, held};
        n_checks++;
        if (got !== e) begin
          n_errors++;
          $display("FAIL cycle %0d outputs: got p=%b r=%b l=%b rp=%b h=%b, required p=%b r=%b l=%b rp=%b h=%b",
                   cyc, got.press, got.rel, got.lng, got.rep, got.held,
                   e.press, e.rel, e.lng, e.rep, e.held);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    #2;
    check_zero("reset_state");
    repeat (3) cycle('0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Short press, long hold with repeats, drop right at the long edge.
    repeat (5) cycle(2'b00);
    repeat (3) cycle(2'b01);
    repeat (3) cycle(2'b00);
    repeat (21) cycle(2'b01);
    repeat (3) cycle(2'b00);
    repeat (7) cycle(2'b01);
    repeat (3) cycle(2'b00);
    // Both channels together, then independent release.
    repeat (10) cycle(2'b11);
    repeat (6) cycle(2'b10);
    repeat (2) cycle(2'b00);
    // Held through reset: no press until the level drops.
    cycle(2'b11);
    pulse_reset(3);
    repeat (5) cycle(2'b11);
    repeat (2) cycle(2'b00);
    repeat (3) cycle(2'b11);
    repeat (2) cycle(2'b00);
    // Reset while in HELD.
    repeat (12) cycle(2'b01);
    pulse_reset(2);
    repeat (4) cycle(2'b01);
    repeat (2) cycle(2'b00);
    repeat (2) cycle(2'b01);
    repeat (2) cycle(2'b00);

    v = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 13) == 0) v[c] = ~v[c];
      cycle(v);
      if ($urandom_range(0, 399) == 0) pulse_reset($urandom_range(1, 3));
    end
    repeat (2) cycle('0);

    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
